fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the 4-bit CPU, sitting directly upstream of `decoder`. It owns the program counter, reads 8-bit instruction words from instruction memory over a req/ack handshake, and latches them in an instruction register. The upper nibble drives the decoder's `opcode` input. The lower nibble is presented to the datapath as an operand. It sequences FETCH → DECODE → EXECUTE, and uses the decoder's `pc_inc` and `halt` outputs to choose the next PC or stop.

## Interface
- `ADDR_W`, default 4: program counter / instruction address width.
- `INSTR_W`, default 8: instruction word width; fixed layout {opcode[3:0], operand[3:0]}.

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  ADDR_W  fetch address; equals `pc`.
- `imem_ack`  in  1  memory has valid `imem_rdata` this cycle.
- `imem_rdata`  in  INSTR_W  instruction word.
- `opcode`  out  4  IR[7:4]; connects to decoder `opcode`.
- `operand`  out  4  IR[3:0]; memory address or immediate for the datapath.
- `instr_valid`  out  1  IR holds the current instruction (DECODE or EXECUTE).
- `exec_done`  in  1  datapath has finished the current instruction.
- `pc_inc`  in  1  from decoder; advance PC on completion.
- `halt`  in  1  from decoder; stop after completion.
- `pc`  out  ADDR_W  current program counter.
- `halted`  out  1  core stopped; sticky until reset.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, HALTED.
- IDLE: entered on reset. Moves to FETCH on the next edge.
- FETCH:
  - `imem_req`=1, `imem_addr`=`pc` held stable until ack.
  - On the edge where `imem_ack`=1: IR ← `imem_rdata`, go to DECODE.
  - With no ack, stays in FETCH indefinitely with no timeout.
- DECODE: one cycle. `instr_valid`=1 and `imem_req`=0. Decoder outputs settle. Goes to EXECUTE unconditionally.
- EXECUTE: `instr_valid`=1. Waits for `exec_done`=1. On that edge:
  - `halt`=1 → HALTED, PC unchanged. `halt` has priority over `pc_inc`.
  - else `pc_inc`=1 → PC ← PC+1 modulo 2^ADDR_W (15 → 0 wraps silently), go to FETCH.
  - else → FETCH with PC unchanged. The same address is re-fetched.
- HALTED:
  - `halted`=1, `imem_req`=0, `instr_valid`=0.
  - IR retains the last instruction.
  - Ignores all inputs. Only `rst_n` exits.
- Inputs outside their states are ignored: `imem_ack` outside FETCH; `exec_done`, `pc_inc`, `halt` outside EXECUTE.
- Reset asserted mid-operation (any state, including mid-handshake) immediately returns everything to reset values. Any pending `imem_req` drops asynchronously.

## Timing
- Reset values:
  - `pc`=0, `imem_addr`=0, `imem_req`=0.
  - IR=8'h00, so `opcode`=0000 (NOP) and `operand`=0.
  - `instr_valid`=0, `halted`=0, state IDLE.
- All outputs are registered or decoded from state/IR only. There is no combinational path from any input to any output.
- `imem_req` rises the cycle after IDLE. It falls in the cycle after the ack edge.
- Minimum instruction latency is 3 cycles (FETCH, DECODE, EXECUTE), with ack in the first FETCH cycle and `exec_done` in the first EXECUTE cycle. Each wait cycle on ack or `exec_done` adds one cycle.
- `pc` updates on the same edge that leaves EXECUTE. The new `imem_addr` is visible in the first cycle of the next FETCH.
- `halted` rises on the edge leaving EXECUTE with `halt`=1.

## Test plan
- Reset: drive `rst_n`=0 mid-FETCH with `imem_req`=1 → all outputs return to reset values asynchronously, before the next clock edge; after release, IDLE → FETCH with `imem_addr`=0.
- Straight-line program: ROM[0]=8'h1A, ROM[1]=8'h3B, ack same cycle, `exec_done` immediate, `pc_inc`=1 → `opcode`=0001/`operand`=A, then 0011/B, on 3-cycle spacing; `pc` steps 0 → 1 → 2.
- Slow memory: ack delayed 4 cycles → `imem_req` and `imem_addr` stay stable for all 5 FETCH cycles; IR changes only on the ack edge; a spurious ack in DECODE is ignored.
- Halt: ROM[2]=8'hF0, `halt`=1 and `pc_inc`=1 together at `exec_done` → `halted`=1, `pc` stays 2, `imem_req` stays 0 for 20 further cycles.
- Wrap-around: `pc`=15, `pc_inc`=1 at `exec_done` → `pc`=0, fetch resumes from address 0.
- No increment: `pc_inc`=0, `halt`=0 at `exec_done` with `pc`=5 → re-fetches address 5; an `exec_done` pulse during FETCH has no effect.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
// The fetch stage holds req/addr stable until ack; rdata is valid only while ack is high.
interface imem_if #(
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 8
);
  logic               req;
  logic [ADDR_W-1:0]  addr;
  logic               ack;
  logic [INSTR_W-1:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage of the 4-bit CPU: owns the PC, fetches over imem_if into the IR and
// steps FETCH -> DECODE -> EXECUTE, using the decoder's pc_inc/halt to pick the next PC.
module fetch_unit #(
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  imem_if.master            imem,
  output logic [3:0]        opcode,
  output logic [3:0]        operand,
  output logic              instr_valid,
  input  logic              exec_done,
  input  logic              pc_inc,
  input  logic              halt,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_DECODE  = 3'd2;
  localparam logic [2:0] S_EXECUTE = 3'd3;
  localparam logic [2:0] S_HALTED  = 3'd4;

  logic [2:0]         state;
  logic [INSTR_W-1:0] ir;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      pc    <= '0;
      ir    <= '0;
    end else begin
      case (state)
        S_IDLE:    state <= S_FETCH;
        S_FETCH: begin
          if (imem.ack) begin
            ir    <= imem.rdata;
            state <= S_DECODE;
          end
        end
        S_DECODE:  state <= S_EXECUTE;
        S_EXECUTE: begin
          // halt wins over pc_inc; with neither, the same address is re-fetched
          if (exec_done) begin
            if (halt) begin
              state <= S_HALTED;
            end else begin
              if (pc_inc) pc <= pc + ADDR_W'(1);
              state <= S_FETCH;
            end
          end
        end
        S_HALTED:  state <= S_HALTED;
        default:   state <= S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from state/IR only, so reset clears them without a clock.
  assign imem.req    = (state == S_FETCH);
  assign imem.addr   = pc;
  assign instr_valid = (state == S_DECODE) || (state == S_EXECUTE);
  assign halted      = (state == S_HALTED);
  assign opcode      = ir[INSTR_W-1 -: 4];
  assign operand     = ir[3:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a small ROM model answers fetches, a scoreboard
// queue holds the instruction expected in the IR at each DECODE.
module tb_fetch_unit;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] opcode, operand;
  logic       instr_valid, exec_done, pc_inc, halt, halted;
  logic [3:0] pc;

  imem_if #(.ADDR_W(4), .INSTR_W(8)) imem ();

  fetch_unit #(.ADDR_W(4), .INSTR_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (imem),
    .opcode      (opcode),
    .operand     (operand),
    .instr_valid (instr_valid),
    .exec_done   (exec_done),
    .pc_inc      (pc_inc),
    .halt        (halt),
    .pc          (pc),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  int         n_cmp  = 0;
  int         n_fail = 0;
  logic [7:0] rom [16];
  logic [7:0] exp_q [$];
  logic [7:0] last_ir;
  logic [3:0] mpc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"},   imem.req, 0);
    chk({tag, "_addr"},  imem.addr, 0);
    chk({tag, "_pc"},    pc, 0);
    chk({tag, "_ir"},    {opcode, operand}, 8'h00);
    chk({tag, "_valid"}, instr_valid, 0);
    chk({tag, "_halt"},  halted, 0);
  endtask

  // Called at a negedge with rst_n low: release, confirm IDLE, then FETCH at address 0.
  task automatic release_reset();
    rst_n = 1'b1;
    #1;
    chk("idle_req", imem.req, 0);
    @(negedge clk);
    chk("post_rst_req", imem.req, 1);
    chk("post_rst_addr", imem.addr, 0);
    mpc     = 4'd0;
    last_ir = 8'h00;
  endtask

  // Runs one instruction starting at a FETCH negedge; ends at the next FETCH/HALTED negedge.
  task automatic run_instr(input int fwait, input bit sp_exec, input bit sp_ack,
                           input int ewait, input bit inc, input bit hlt);
    logic [7:0] e;
    for (int w = 0; w < fwait; w++) begin
      chk("fetch_req", imem.req, 1);
      chk("fetch_addr", imem.addr, mpc);
      chk("fetch_ir_hold", {opcode, operand}, last_ir);
      imem.ack   = 1'b0;
      imem.rdata = ~rom[mpc];
      exec_done  = sp_exec;
      halt       = sp_exec;
      pc_inc     = sp_exec;
      @(negedge clk);
    end
    chk("fetch_req", imem.req, 1);
    chk("fetch_addr", imem.addr, mpc);
    chk("fetch_pc", pc, mpc);
    imem.ack   = 1'b1;
    imem.rdata = rom[mpc];
    exec_done  = 1'b0;
    halt       = 1'b0;
    pc_inc     = 1'b0;
    exp_q.push_back(rom[mpc]);
    @(negedge clk);
    // DECODE
    imem.ack = 1'b0;
    chk("dec_valid", instr_valid, 1);
    chk("dec_req", imem.req, 0);
    chk("sb_level", exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("dec_ir", {opcode, operand}, e);
      last_ir = e;
    end
    if (sp_ack) begin
      imem.ack   = 1'b1;
      imem.rdata = 8'h5C;
    end
    @(negedge clk);
    // EXECUTE
    imem.ack = 1'b0;
    for (int w = 0; w < ewait; w++) begin
      chk("exe_valid", instr_valid, 1);
      chk("exe_ir", {opcode, operand}, last_ir);
      pc_inc = inc;
      halt   = hlt;
      @(negedge clk);
    end
    chk("exe_valid", instr_valid, 1);
    chk("exe_req", imem.req, 0);
    exec_done = 1'b1;
    pc_inc    = inc;
    halt      = hlt;
    @(negedge clk);
    exec_done = 1'b0;
    pc_inc    = 1'b0;
    halt      = 1'b0;
    if (!hlt && inc) mpc = mpc + 4'd1;
    chk("next_pc", pc, mpc);
    chk("next_halted", halted, hlt);
  endtask

  initial begin
    logic [3:0] ii;
    for (int i = 0; i < 16; i++) begin
      ii     = 4'(i);
      rom[i] = {ii, ~ii};
    end
    rom[0] = 8'h1A;
    rom[1] = 8'h3B;
    rom[2] = 8'hF0;

    rst_n      = 1'b0;
    imem.ack   = 1'b0;
    imem.rdata = 8'h00;
    exec_done  = 1'b0;
    pc_inc     = 1'b0;
    halt       = 1'b0;
    mpc        = 4'd0;
    last_ir    = 8'h00;
    @(negedge clk);
    chk_reset_vals("rst");
    release_reset();

    // Straight-line 1A, 3B, then slow memory on F0 with a spurious DECODE ack, then halt.
    run_instr(0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    run_instr(0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    run_instr(4, 1'b0, 1'b1, 2, 1'b1, 1'b1);
    for (int c = 0; c < 20; c++) begin
      imem.ack   = 1'($urandom);
      imem.rdata = 8'($urandom);
      exec_done  = 1'($urandom);
      pc_inc     = 1'($urandom);
      halt       = 1'($urandom);
      @(negedge clk);
      chk("hlt_halted", halted, 1);
      chk("hlt_req", imem.req, 0);
      chk("hlt_valid", instr_valid, 0);
      chk("hlt_pc", pc, 2);
      chk("hlt_ir", {opcode, operand}, 8'hF0);
    end
    imem.ack  = 1'b0;
    exec_done = 1'b0;
    pc_inc    = 1'b0;
    halt      = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk_reset_vals("rst_halted");
    @(negedge clk);
    release_reset();

    // Walk to pc=5, re-fetch it without increment, then on to the 15 -> 0 wrap.
    for (int i = 0; i < 5; i++) run_instr(0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    run_instr(0, 1'b0, 1'b0, 1, 1'b0, 1'b0);
    chk("noinc_addr", imem.addr, 5);
    run_instr(2, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    for (int i = 6; i < 16; i++) run_instr(0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    chk("wrap_addr", imem.addr, 0);
    run_instr(1, 1'b0, 1'b0, 0, 1'b1, 1'b0);

    // Reset mid-FETCH at address 1 with req high: must clear before the next clock edge.
    chk("pre_rst_req", imem.req, 1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_fetch");
    @(negedge clk);
    release_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
